// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] vec_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: rotate requests so ptr lands on bit 0,
// take the lowest set bit, then rotate the winner back into place.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx,
  output logic [N_REQ-1:0] win_onehot
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] sel;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + ptr];
    end
  end

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) sel = IDX_W'(i);
    end
  end

  assign any        = |req;
  assign win_idx    = sel + ptr;
  assign win_onehot = any ? (4'b0001 << win_idx) : 4'b0000;

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with owner release and a hold
// timeout that force-releases a grant after MAX_HOLD cycles.
//
//   state | meaning
//   IDLE  | no owner; issues a grant when en=1 and any req is set
//   GRANT | one owner holds gnt until done, request drop or hold timeout
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic             any;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;

  logic owner_rel;
  logic hold_hit;

  rr_pick4 u_pick (
    .req        (req),
    .ptr        (ptr),
    .any        (any),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  assign owner_rel = done || !req[gnt_idx];
  assign hold_hit  = (hold_cnt == HOLD_LAST);
  assign gnt_valid = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && any) begin
            state    <= GRANT;
            gnt      <= win_onehot;
            gnt_idx  <= win_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (owner_rel || hold_hit) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= gnt_idx + 1'b1;
            hold_cnt <= '0;
            // A timeout is only reported when the owner had not let go itself.
            timeout  <= hold_hit && !owner_rel;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD at its default of 16.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0000; done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b idx=%0d valid=%b timeout=%b, want 0000/0/0/0",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: valid=%b, want 0", gnt_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_gnt;
    en = 1'b1; req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp_gnt = 4'b0001 << order[g];
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (gnt !== exp_gnt || gnt_idx !== order[g] || gnt_valid !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant%0d_cyc%0d: gnt=%b idx=%0d valid=%b, want %b/%0d/1",
                   g, c, gnt, gnt_idx, gnt_valid, exp_gnt, order[g]);
        end
        if (c == 2) begin
          done = 1'b1;
          if (g == 4) req = 4'b0000;
        end
        tick();
      end
      done = 1'b0;
      checks++;
      if (gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== order[g]) begin
        errors++;
        $display("FAIL rr_gap%0d: valid=%b timeout=%b idx=%0d, want 0/0/%0d",
                 g, gnt_valid, timeout, gnt_idx, order[g]);
      end
      if (g != 4) tick();
    end
  endtask

  // ptr=1 on entry; requester 2 wins, holds for 16 cycles, then times out.
  task automatic test_timeout();
    req = 4'b0100;
    tick();
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d: gnt=%b idx=%0d timeout=%b, want 0100/2/0",
                 c, gnt, gnt_idx, timeout);
      end
      tick();
    end
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b1 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL timeout_release: gnt=%b valid=%b timeout=%b idx=%0d, want 0000/0/1/2",
               gnt, gnt_valid, timeout, gnt_idx);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant: gnt=%b timeout=%b, want 0100/0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: valid=%b timeout=%b, want 0/0", gnt_valid, timeout);
    end
  endtask

  // ptr=3 on entry; requester 1 wins, others arrive mid-grant.
  task automatic test_no_preempt();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL np_grant: gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
    req = 4'b1011;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL np_hold1: gnt=%b, want 0010", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL np_hold2: gnt=%b, want 0010", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 4'b1001;
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL np_release: valid=%b timeout=%b, want 0/0", gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      errors++;
      $display("FAIL np_next: gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick();
  endtask

  // ptr=0 on entry.
  task automatic test_enable();
    en = 1'b0; req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_low_cyc%0d: valid=%b, want 0", c, gnt_valid);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL en_grant: gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
    en = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL en_low_keeps_owner: gnt=%b, want 0010", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_low_no_regrant: valid=%b, want 0", gnt_valid);
    end
    en = 1'b1; req = 4'b0000;
    tick();
  endtask

  // ptr=2 on entry; requester 3 wins, then reset clears ptr back to 0.
  task automatic test_reset_mid_grant();
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      errors++;
      $display("FAIL rst_pre: gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    checks++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: gnt=%b idx=%0d valid=%b timeout=%b, want 0000/0/0/0",
               gnt, gnt_idx, gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL rst_regrant: gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
  endtask

  // Owner 1 active on entry; done and request drop arrive together.
  task automatic test_done_and_drop();
    done = 1'b1; req = 4'b1000;
    tick();
    done = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL dd_release: valid=%b timeout=%b, want 0/0", gnt_valid, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      errors++;
      $display("FAIL dd_next: gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
    end
  endtask

  // Owner 3 active on entry (first cycle); done lands on the 16th cycle.
  task automatic test_done_at_limit();
    for (int c = 1; c < 16; c++) tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL lim_cyc16: gnt=%b, want 1000", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL lim_done: valid=%b timeout=%b, want 0/0", gnt_valid, timeout);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_no_preempt();
    test_enable();
    test_reset_mid_grant();
    test_done_and_drop();
    test_done_at_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
